// File: rtl/tcu_priv_reg_arbiter.sv
// Round-robin arbiter sharing the TCU privileged register port between NUM_REQ
// requesters, with lock ownership, read-data return routing and a lock watchdog.

module tcu_priv_reg_lane #(
  parameter int BW = 8,
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          req_en,
  input  logic          grant,
  input  logic          reg_stall,
  input  logic          rd_hit,
  input  logic [BW-1:0] wben,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] reg_rdata,
  output logic          stall,
  output logic          fwd_en,
  output logic [BW-1:0] fwd_wben,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_wdata,
  output logic [DW-1:0] rdata
);
  logic sel;

  assign sel       = req_en & grant;
  assign stall     = req_en & (~grant | reg_stall);
  assign fwd_en    = sel;
  assign fwd_wben  = sel ? wben  : '0;
  assign fwd_addr  = sel ? addr  : '0;
  assign fwd_wdata = sel ? wdata : '0;
  assign rdata     = rd_hit ? reg_rdata : '0;
endmodule

module tcu_priv_reg_arbiter #(
  parameter int NUM_REQ           = 3,
  parameter int LOCK_TIMEOUT      = 1024,
  parameter int TCU_REG_BSEL_SIZE = 8,
  parameter int TCU_REG_ADDR_SIZE = 32,
  parameter int TCU_REG_DATA_SIZE = 64
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [NUM_REQ-1:0]                   req_en_i,
  input  logic [NUM_REQ-1:0]                   req_lock_i,
  input  logic [NUM_REQ*TCU_REG_BSEL_SIZE-1:0] req_wben_i,
  input  logic [NUM_REQ*TCU_REG_ADDR_SIZE-1:0] req_addr_i,
  input  logic [NUM_REQ*TCU_REG_DATA_SIZE-1:0] req_wdata_i,
  output logic [NUM_REQ*TCU_REG_DATA_SIZE-1:0] req_rdata_o,
  output logic [NUM_REQ-1:0]                   req_stall_o,
  output logic                                 reg_en_o,
  output logic [TCU_REG_BSEL_SIZE-1:0]         reg_wben_o,
  output logic [TCU_REG_ADDR_SIZE-1:0]         reg_addr_o,
  output logic [TCU_REG_DATA_SIZE-1:0]         reg_wdata_o,
  input  logic [TCU_REG_DATA_SIZE-1:0]         reg_rdata_i,
  input  logic                                 reg_stall_i,
  output logic                                 lock_timeout_o,
  output logic [NUM_REQ-1:0]                   grant_o
);
  localparam int N  = NUM_REQ;
  localparam int BW = TCU_REG_BSEL_SIZE;
  localparam int AW = TCU_REG_ADDR_SIZE;
  localparam int DW = TCU_REG_DATA_SIZE;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  logic [SW-1:0] r_rr;
  logic          r_lock_vld;
  logic [SW-1:0] r_lock_sel;
  logic          r_hold;
  logic [SW-1:0] r_hold_sel;
  logic          r_rd_vld;
  logic [SW-1:0] r_rd_sel;
  logic [CW-1:0] r_cnt;
  logic          r_to;

  logic [N-1:0]  rr_gnt, gnt_raw, grant;
  logic [SW-1:0] g_idx, idx;
  logic          rr_found;
  logic          accept, owner_lock, rel, wd_hit, expire, take, rd_acc;

  logic [N-1:0]          fwd_en;
  logic [N-1:0][BW-1:0]  fwd_wben;
  logic [N-1:0][AW-1:0]  fwd_addr;
  logic [N-1:0][DW-1:0]  fwd_wdata;

  function automatic logic [SW-1:0] nxt_idx(input logic [SW-1:0] x);
    return (x == SW'(N-1)) ? '0 : x + 1'b1;
  endfunction

  // Priority: lock owner, then a stalled in-flight access, then round-robin.
  always_comb begin
    rr_gnt   = '0;
    rr_found = 1'b0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = SW'((int'(r_rr) + i) % N);
      if (!rr_found && req_en_i[idx]) begin
        rr_gnt[idx] = 1'b1;
        rr_found    = 1'b1;
      end
    end
    if (r_lock_vld)  gnt_raw = N'(1) << r_lock_sel;
    else if (r_hold) gnt_raw = N'(1) << r_hold_sel;
    else             gnt_raw = rr_gnt;
    grant = reset_n_i ? gnt_raw : '0;
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < N; i++)
      if (grant[i]) g_idx = SW'(i);
  end

  for (genvar n = 0; n < N; n++) begin : g_lane
    tcu_priv_reg_lane #(.BW(BW), .AW(AW), .DW(DW)) u_lane (
      .req_en    (req_en_i[n]),
      .grant     (grant[n]),
      .reg_stall (reg_stall_i),
      .rd_hit    (r_rd_vld && (r_rd_sel == SW'(n))),
      .wben      (req_wben_i[n*BW +: BW]),
      .addr      (req_addr_i[n*AW +: AW]),
      .wdata     (req_wdata_i[n*DW +: DW]),
      .reg_rdata (reg_rdata_i),
      .stall     (req_stall_o[n]),
      .fwd_en    (fwd_en[n]),
      .fwd_wben  (fwd_wben[n]),
      .fwd_addr  (fwd_addr[n]),
      .fwd_wdata (fwd_wdata[n]),
      .rdata     (req_rdata_o[n*DW +: DW])
    );
  end

  // At most one lane is selected, so an OR-reduce is the mux.
  always_comb begin
    reg_wben_o  = '0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    for (int i = 0; i < N; i++) begin
      reg_wben_o  = reg_wben_o  | fwd_wben[i];
      reg_addr_o  = reg_addr_o  | fwd_addr[i];
      reg_wdata_o = reg_wdata_o | fwd_wdata[i];
    end
  end

  assign reg_en_o       = |fwd_en;
  assign grant_o        = grant;
  assign lock_timeout_o = r_to;

  assign accept     = reg_en_o & ~reg_stall_i;
  assign rd_acc     = accept & (reg_wben_o == '0);
  assign owner_lock = req_lock_i[r_lock_sel];
  assign rel        = r_lock_vld & ~owner_lock;
  // Fires on the edge where the counter would reach LOCK_TIMEOUT-1.
  assign wd_hit     = (LOCK_TIMEOUT > 0) && r_lock_vld &&
                      ((int'(r_cnt) + 1) >= (LOCK_TIMEOUT - 1));
  assign expire     = wd_hit & ~rel;
  assign take       = accept & req_lock_i[g_idx] & ~r_lock_vld;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rr       <= '0;
      r_lock_vld <= 1'b0;
      r_lock_sel <= '0;
      r_hold     <= 1'b0;
      r_hold_sel <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_sel   <= '0;
      r_cnt      <= '0;
      r_to       <= 1'b0;
    end else begin
      if (accept)      r_rr <= nxt_idx(g_idx);
      else if (expire) r_rr <= nxt_idx(r_lock_sel);

      if (rel || expire) r_lock_vld <= 1'b0;
      else if (take) begin
        r_lock_vld <= 1'b1;
        r_lock_sel <= g_idx;
      end

      if (!r_lock_vld || rel || expire || take) r_cnt <= '0;
      else                                      r_cnt <= r_cnt + 1'b1;

      r_to <= expire;

      if (accept) r_hold <= 1'b0;
      else if (reg_en_o && reg_stall_i) begin
        r_hold     <= 1'b1;
        r_hold_sel <= g_idx;
      end

      r_rd_vld <= rd_acc;
      if (rd_acc) r_rd_sel <= g_idx;
    end
  end
endmodule
